// File: rtl/cache_mux_types.sv
// Shared cache-datapath types: mux selects used by the cache datapaths and
// the physical-memory arbiter's state encoding and one-hot grant values.
package cache_mux_types;

  // Cache datapath selects.
  typedef enum logic [1:0] {
    WDATA_SEL_CPU  = 2'b00,
    WDATA_SEL_PMEM = 2'b01,
    WDATA_SEL_HOLD = 2'b10
  } wdata_mux_sel_t;

  typedef enum logic {
    PADDR_SEL_CPU = 1'b0,
    PADDR_SEL_TAG = 1'b1
  } pmem_addr_mux_sel_t;

  // Arbiter FSM: DONE is a one-cycle guard between a response and the next
  // arbitration, so a request still held at the response edge is not re-served.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    I_SERVE = 2'b01,
    D_SERVE = 2'b10,
    DONE    = 2'b11
  } pmem_arb_state_t;

  // One-hot owner of the memory port.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // Pending requests seen by the winner selector.
  typedef struct packed {
    logic d_req;
    logic i_req;
  } pmem_arb_req_t;

  // True while a cache owns the memory port.
  function automatic logic is_serving(input pmem_arb_state_t s);
    return (s == I_SERVE) || (s == D_SERVE);
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle between the I-cache, the D-cache, the cacheline adaptor and the
// arbiter. The arbiter takes the slave view; the caches/adaptor side
// (or a testbench standing in for them) takes the master view.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Cacheline adaptor side
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  // Current owner
  logic [1:0]        grant;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output grant
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  grant
  );

endinterface

// File: rtl/pmem_arb_select.sv
// Winner selection for the physical-memory arbiter (purely combinational).
// Build option PMEM_ARB_ROUND_ROBIN_EN: when defined, a collision goes to the
// requester that was not granted last; when undefined, D always beats I and
// the last-grant input is ignored.
module pmem_arb_select
  import cache_mux_types::*;
(
  input  pmem_arb_req_t i_reqs,
  input  logic          i_last_d,  // 1: D was granted last, 0: I was
  output logic [1:0]    o_winner
);

`ifdef PMEM_ARB_ROUND_ROBIN_EN

  // Alternate owners on a collision; a lone requester always wins.
  always_comb begin
    // NOTE: default first so every path assigns o_winner and no latch is inferred.
    o_winner = GRANT_NONE;
    if (i_reqs.i_req && i_reqs.d_req) begin
      o_winner = i_last_d ? GRANT_I : GRANT_D;
    end else if (i_reqs.d_req) begin
      o_winner = GRANT_D;
    end else if (i_reqs.i_req) begin
      o_winner = GRANT_I;
    end
  end

`else

  // Fixed priority has no history to consult.
  logic w_unused_last_d;
  assign w_unused_last_d = i_last_d;

  // Fixed priority: D over I.
  always_comb begin
    o_winner = GRANT_NONE;
    if (i_reqs.d_req) begin
      o_winner = GRANT_D;
    end else if (i_reqs.i_req) begin
      o_winner = GRANT_I;
    end
  end

`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter: shares one cacheline adaptor between the I-cache
// (fills only) and the D-cache (fills and writebacks). A transaction is
// IDLE -> *_SERVE -> DONE -> IDLE; all pmem request fields are registered at
// the grant edge and held until the adaptor responds.
// Build option PMEM_ARB_ROUND_ROBIN_EN selects round-robin collision handling
// (with a last-grant register); without it, D has fixed priority over I.
module pmem_arbiter
  import cache_mux_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active low
  pmem_arbiter_if.slave  bus
);

  pmem_arb_state_t   r_state;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;
  logic [1:0]        r_grant;

  pmem_arb_req_t     w_reqs;
  logic [1:0]        w_winner;
  logic              w_last_d;
  logic              w_arbitrate;

  // A D request is either a fill or a writeback.
  assign w_reqs.i_req = bus.i_read;
  assign w_reqs.d_req = bus.d_read | bus.d_write;

  // Arbitration only happens in IDLE; DONE deliberately ignores requests.
  assign w_arbitrate = (r_state == IDLE) && (w_winner != GRANT_NONE);

  pmem_arb_select u_select (
    .i_reqs   (w_reqs),
    .i_last_d (w_last_d),
    .o_winner (w_winner)
  );

`ifdef PMEM_ARB_ROUND_ROBIN_EN

  logic r_last_d;

  // Remember who won the most recent grant; reset leaves I as last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_arbitrate) begin
      r_last_d <= (w_winner == GRANT_D);
    end
  end

  assign w_last_d = r_last_d;

`else

  assign w_last_d = 1'b0;

`endif

  // Transaction FSM with registered pmem request fields and grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the latched address/data are reset as well, so every pmem output
      // is a known zero while rst is low, even mid-transaction.
      r_state        <= IDLE;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_grant        <= GRANT_NONE;
    end else begin
      // NOTE: non-blocking assignments, so every register here updates from
      // pre-edge values regardless of statement order.
      case (r_state)
        IDLE: begin
          if (w_winner == GRANT_D) begin
            // Both strobes high means writeback: the dirty line must go first.
            r_state        <= D_SERVE;
            r_grant        <= GRANT_D;
            r_pmem_address <= bus.d_address;
            r_pmem_wdata   <= bus.d_wdata;
            r_pmem_write   <= bus.d_write;
            r_pmem_read    <= ~bus.d_write;
          end else if (w_winner == GRANT_I) begin
            r_state        <= I_SERVE;
            r_grant        <= GRANT_I;
            r_pmem_address <= bus.i_address;
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
          end
        end
        I_SERVE, D_SERVE: begin
          // The request inputs are not looked at here: a requester that drops
          // early still sees its transaction finish.
          if (bus.pmem_resp) begin
            r_state      <= DONE;
            r_grant      <= GRANT_NONE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Adaptor-facing outputs come straight from the latched registers.
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.grant        = r_grant;

  // Completion is forwarded in the same cycle only to the current owner; a
  // response arriving in IDLE or DONE reaches nobody.
  assign bus.i_resp  = bus.pmem_resp & is_serving(r_state) & (r_state == I_SERVE);
  assign bus.d_resp  = bus.pmem_resp & is_serving(r_state) & (r_state == D_SERVE);
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: physical address width in bits.
REQ-002 Parameter LINE_W, default 256: cache line width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_read  input  1  I-cache line-fill request; held high until i_resp.
REQ-006 i_address  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  fill data returned to the I-cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to the I-cache.
REQ-009 d_read  input  1  D-cache fill request; held high until d_resp.
REQ-010 d_write  input  1  D-cache writeback request; held high until d_resp.
REQ-011 d_address  input  ADDR_W  D-cache line address.
REQ-012 d_wdata  input  LINE_W  D-cache writeback data.
REQ-013 d_rdata  output  LINE_W  fill data returned to the D-cache.
REQ-014 d_resp  output  1  one-cycle completion pulse to the D-cache.
REQ-015 pmem_read, pmem_write  output  1 each  request to the cacheline adaptor.
REQ-016 pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W  latched request fields.
REQ-017 pmem_rdata  input  LINE_W; pmem_resp  input  1  adaptor data and completion.
REQ-018 grant  output  2  one-hot owner: 2'b01 = I, 2'b10 = D, 2'b00 = none.

Function
REQ-019 FSM states: IDLE, I_SERVE, D_SERVE, DONE.
REQ-020 In IDLE with any request pending, the FSM SHALL select a winner and move to I_SERVE or D_SERVE on the next edge.
REQ-020a At that same edge, the winner's address is latched, and for D its wdata and operation are latched too.
REQ-021 pmem_read/pmem_write/pmem_address/pmem_wdata SHALL be driven only from latched registers in *_SERVE, and are stable for the whole transaction.
REQ-022 I_SERVE SHALL drive pmem_read = 1 and pmem_write = 0.
REQ-022a D_SERVE SHALL drive the latched operation; if d_read and d_write are both high at grant, the operation is a write.
REQ-023 i_resp = pmem_resp in I_SERVE and d_resp = pmem_resp in D_SERVE, combinationally in the same cycle.
REQ-023a i_rdata and d_rdata SHALL pass pmem_rdata through.
REQ-024 On pmem_resp in *_SERVE, the FSM SHALL go to DONE for exactly one cycle, then to IDLE.
REQ-024a DONE SHALL grant nothing, so that a request held high through the resp edge is not serviced twice.
REQ-025 Minimum turnaround is request edge to pmem request = 1 cycle; back-to-back transactions are separated by IDLE + DONE = 2 cycles.
REQ-026 A request that deasserts while its transaction is in *_SERVE is illegal, and the transaction SHALL still complete.
REQ-027 pmem_resp received in IDLE or DONE SHALL be ignored: no resp to either cache and no state change.
REQ-028 grant SHALL reflect the current state: 01 in I_SERVE, 10 in D_SERVE, 00 otherwise.

Reset
REQ-029 rst low SHALL immediately put the FSM in IDLE, including mid-transaction.
REQ-029a While rst is low, all pmem_* strobes, i_resp, d_resp and grant are 0; latched address/data are 0; the round-robin pointer is I-last.
REQ-030 After rst deasserts, the first arbitration SHALL occur at the first rising edge with a request pending.

Configuration
REQ-031 Macro PMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous I and D requests in IDLE, the requester not granted last wins; a 1-bit last-grant register updates at each grant.
REQ-032 Macro PMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, D over I, and no last-grant register exists.

Structure
REQ-033 The state enum (pmem_arb_state_t) and grant encoding constants SHALL live in cache_mux_types, alongside the existing cache mux selects.
REQ-034 Winner selection SHALL be one combinational sub-module, pmem_arb_select (inputs: requests, last-grant; output: winner), whose contents are conditioned on the macro.

Verification
REQ-035 Single I fill: i_read = 1, i_address = 0x0000_1000, adaptor resp 4 cycles after pmem_read.
- pmem_address must equal 0x0000_1000.
- i_resp must be one pulse with i_rdata = pmem_rdata.
- FSM returns to IDLE 2 cycles after the resp.
REQ-036 Writeback: d_write = 1, d_address = 0x8000_0040, d_wdata = {8{32'hDEADBEEF}}.
- pmem_write must be 1 with pmem_wdata unchanged until pmem_resp.
- d_resp must pulse once; i_resp must stay 0.
REQ-037 Simultaneous requests: i_read and d_read both raised in the same cycle, repeated three times.
- Macro on: grants alternate D, I, D (the pointer starts I-last).
- Macro off: D is served first on every collision.
REQ-038 No double service: the requester holds its request one cycle past its resp.
- No second pmem request may be issued for it.
- grant must be 00 in DONE.
REQ-039 Mid-transaction reset: rst driven low two cycles into D_SERVE.
- pmem_write, d_resp and grant must drop to 0 asynchronously.
- A stray pmem_resp after release must be ignored.
REQ-040 Combined read+write: d_read and d_write both high at grant, with pmem_resp held low for 10 cycles.
- The operation must be a write, with pmem_address constant for all 10 cycles.
